// File: rtl/signed_minmax_scanner.sv
// Signed min/max scanner: walks a frame of samples through one shared signed
// comparator, tracking the minimum, the maximum and the first index of each.

// Purely combinational signed magnitude comparator.
module comparator_signed #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         lt_c,
    output logic         eq_c,
    output logic         gt_c
);

    assign lt_c = $signed(a) <  $signed(b);
    assign eq_c = (a == b);
    assign gt_c = $signed(a) >  $signed(b);

endmodule

module signed_minmax_scanner #(
    parameter  int unsigned DATA_W      = 8,
    parameter  int unsigned NUM_SAMPLES = 4,
    localparam int unsigned IDX_W       = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              res_ready,
    output logic              res_valid,
    output logic [DATA_W-1:0] min_val,
    output logic [DATA_W-1:0] max_val,
    output logic [IDX_W-1:0]  min_idx,
    output logic [IDX_W-1:0]  max_idx,
    output logic              busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_CMP_MIN,
        ST_CMP_MAX,
        ST_DONE
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [IDX_W-1:0]    count_q;
    logic [IDX_W-1:0]    count_d;
    logic [DATA_W-1:0]   hold_q;
    logic [DATA_W-1:0]   hold_d;
    logic [DATA_W-1:0]   min_d;
    logic [DATA_W-1:0]   max_d;
    logic [IDX_W-1:0]    min_idx_d;
    logic [IDX_W-1:0]    max_idx_d;
    logic                in_ready_d;
    logic                res_valid_d;
    logic                busy_d;

    logic [DATA_W-1:0]   cmp_b;
    logic                cmp_lt;
    logic                cmp_eq;
    logic                cmp_gt;

    // Comparator operand select: the held sample against the running min or max.
    always_comb begin
        cmp_b = (state_q == ST_CMP_MIN) ? min_val : max_val;
    end

    comparator_signed #(
        .W (DATA_W)
    ) u_cmp (
        .a    (hold_q),
        .b    (cmp_b),
        .lt_c (cmp_lt),
        .eq_c (cmp_eq),
        .gt_c (cmp_gt)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, datapath updates and output decode of the upcoming state.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        hold_d    = hold_q;
        min_d     = min_val;
        max_d     = max_val;
        min_idx_d = min_idx;
        max_idx_d = max_idx;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ACCEPT;
                    count_d = '0;
                end
            end
            ST_ACCEPT: begin
                if (in_valid) begin
                    if (count_q == '0) begin
                        min_d     = in_data;
                        max_d     = in_data;
                        min_idx_d = '0;
                        max_idx_d = '0;
                        if (count_q == LAST_IDX) begin
                            state_d = ST_DONE;
                        end else begin
                            count_d = count_q + IDX_W'(1);
                        end
                    end else begin
                        hold_d  = in_data;
                        state_d = ST_CMP_MIN;
                    end
                end
            end
            ST_CMP_MIN: begin
                // Strictly less only: ties keep the earlier index.
                if (cmp_lt && !cmp_eq) begin
                    min_d     = hold_q;
                    min_idx_d = count_q;
                end
                state_d = ST_CMP_MAX;
            end
            ST_CMP_MAX: begin
                if (cmp_gt && !cmp_eq) begin
                    max_d     = hold_q;
                    max_idx_d = count_q;
                end
                if (count_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    count_d = count_q + IDX_W'(1);
                    state_d = ST_ACCEPT;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_ACCEPT);
        res_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    // Datapath and status registers; status flags track the state register exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            hold_q    <= '0;
            min_val   <= '0;
            max_val   <= '0;
            min_idx   <= '0;
            max_idx   <= '0;
            in_ready  <= 1'b0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            count_q   <= count_d;
            hold_q    <= hold_d;
            min_val   <= min_d;
            max_val   <= max_d;
            min_idx   <= min_idx_d;
            max_idx   <= max_idx_d;
            in_ready  <= in_ready_d;
            res_valid <= res_valid_d;
            busy      <= busy_d;
        end
    end

endmodule
